clock_recovery_sequencer: RTL

CLOCK_RECOVERY_SEQUENCER -- requirements
Module: Clock_Recovery_Sequencer

---
 rtl/clock_recovery_sequencer_pkg.sv | 23 ++
 rtl/Sync_2FF.sv | 21 ++
 rtl/clock_recovery_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/clock_recovery_sequencer_pkg.sv
// rtl/clock_recovery_sequencer_pkg.sv - state encoding, default cycle counts and widths for the clock recovery sequencer
package clock_recovery_sequencer_pkg;

    localparam logic [2:0] ST_RESET_PLL = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    localparam int DEF_RESET_CYCLES  = 64;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_SETTLE_CYCLES = 4096;
    localparam int DEF_MAX_RETRIES   = 7;

    localparam int RELOCK_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/Sync_2FF.sv
// rtl/Sync_2FF.sv - two-flop synchroniser for a single asynchronous level, cleared by nReset
module Sync_2FF (
    input  logic Clk,
    input  logic nReset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clock_recovery_sequencer.sv
// rtl/clock_recovery_sequencer.sv - PLL reset/lock/settle sequencer gating the recovered clock domain
module clock_recovery_sequencer
    import clock_recovery_sequencer_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                PLL_Locked,
    input  logic                Restart,
    output logic                PLL_Reset,
    output logic                Rec_Reset_Req,
    output logic                Ready,
    output logic                Fault,
    output logic [2:0]          State,
    output logic [RELOCK_W-1:0] Relock_Count
);

    localparam int TW = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)) + 1;
    localparam int RW = $clog2(MAX_RETRIES + 1);

    logic                lk;
    logic [TW-1:0]       timer;
    logic [RW-1:0]       retry;
    logic [2:0]          state_nx;
    logic [RW-1:0]       retry_nx;
    logic [RELOCK_W-1:0] relock_nx;
    logic                tmr_clr;

    Sync_2FF u_lock_sync (
        .Clk    (Clk),
        .nReset (nReset),
        .d      (PLL_Locked),
        .q      (lk)
    );

    // Restart wins over every other transition; tmr_clr marks each state entry.
    always_comb begin
        state_nx  = State;
        retry_nx  = retry;
        relock_nx = Relock_Count;
        tmr_clr   = 1'b0;
        if (Restart) begin
            state_nx = ST_RESET_PLL;
            tmr_clr  = 1'b1;
            if (State == ST_FAULT) begin
                retry_nx = '0;
            end
        end else begin
            case (State)
                ST_RESET_PLL: begin
                    if (timer == TW'(RESET_CYCLES - 1)) begin
                        state_nx = ST_WAIT_LOCK;
                        tmr_clr  = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk) begin
                        state_nx = ST_SETTLE;
                        tmr_clr  = 1'b1;
                    end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                        retry_nx = retry + RW'(1);
                        tmr_clr  = 1'b1;
                        state_nx = (retry_nx == RW'(MAX_RETRIES)) ? ST_FAULT : ST_RESET_PLL;
                    end
                end
                ST_SETTLE: begin
                    if (!lk) begin
                        state_nx = ST_WAIT_LOCK;
                        tmr_clr  = 1'b1;
                    end else if (timer == TW'(SETTLE_CYCLES)) begin
                        state_nx = ST_RUN;
                        retry_nx = '0;
                        tmr_clr  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lk) begin
                        state_nx = ST_RESET_PLL;
                        tmr_clr  = 1'b1;
                        if (Relock_Count != '1) begin
                            relock_nx = Relock_Count + RELOCK_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                end
                default: begin
                    state_nx = ST_RESET_PLL;
                    tmr_clr  = 1'b1;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they land on the same edge as State.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            State         <= ST_RESET_PLL;
            timer         <= '0;
            retry         <= '0;
            Relock_Count  <= '0;
            PLL_Reset     <= 1'b1;
            Rec_Reset_Req <= 1'b1;
            Ready         <= 1'b0;
            Fault         <= 1'b0;
        end else begin
            State        <= state_nx;
            retry        <= retry_nx;
            Relock_Count <= relock_nx;
            if (tmr_clr) begin
                timer <= '0;
            end else if (State == ST_RESET_PLL || State == ST_WAIT_LOCK || State == ST_SETTLE) begin
                timer <= timer + TW'(1);
            end
            PLL_Reset     <= (state_nx == ST_RESET_PLL) || (state_nx == ST_FAULT);
            Rec_Reset_Req <= (state_nx != ST_RUN);
            Ready         <= (state_nx == ST_RUN);
            Fault         <= (state_nx == ST_FAULT);
        end
    end

endmodule
